// File: rtl/corep_pkg.sv
// Shared core types and constants used by the front-end predictors and fetch checkpoints.
package corep;
    localparam int RAS_ENTRIES     = 16;
    localparam int LOG_RAS_ENTRIES = 4;

    typedef logic [37:0]                PC38_t;
    typedef logic [LOG_RAS_ENTRIES-1:0] RAS_idx_t;
    typedef logic [LOG_RAS_ENTRIES:0]   RAS_count_t;

    localparam PC38_t INIT_PC38 = 38'h0;
endpackage

// File: rtl/ras.sv
// Return address stack: circular flop array with top pointer and saturating occupancy count.
// Checkpointed pointer state can be restored via the update port after a mispredict.
module ras #(
    parameter int          RAS_ENTRIES = corep::RAS_ENTRIES,
    parameter corep::PC38_t INIT_PC38  = corep::INIT_PC38
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              push_valid,
    input  corep::PC38_t      push_pc38,
    input  logic              pop_valid,
    input  logic              update_valid,
    input  corep::RAS_idx_t   update_ras_index,
    input  corep::RAS_count_t update_ras_count,
    output corep::PC38_t      ret_pc38,
    output corep::RAS_idx_t   ras_index,
    output corep::RAS_count_t ras_count,
    output logic              ras_empty
);

    localparam corep::RAS_count_t FULL = corep::RAS_count_t'(RAS_ENTRIES);

    corep::PC38_t      stack [RAS_ENTRIES];
    corep::RAS_idx_t   ptr;
    corep::RAS_idx_t   ptr_inc;
    corep::RAS_idx_t   ptr_dec;
    corep::RAS_count_t count;
    corep::RAS_count_t update_count_clamped;

    always_comb begin
        ptr_inc              = ptr + 1'b1;
        ptr_dec              = ptr - 1'b1;
        update_count_clamped = (update_ras_count > FULL) ? FULL : update_ras_count;
    end

    // Index arithmetic wraps naturally because the stack depth is a power of two.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                stack[i] <= INIT_PC38;
            end
            ptr   <= '0;
            count <= '0;
        end else if (update_valid) begin
            ptr   <= update_ras_index;
            count <= update_count_clamped;
        end else if (push_valid && pop_valid) begin
            stack[ptr] <= push_pc38;
            if (count == '0) begin
                count <= corep::RAS_count_t'(1);
            end
        end else if (push_valid) begin
            ptr            <= ptr_inc;
            stack[ptr_inc] <= push_pc38;
            if (count != FULL) begin
                count <= count + 1'b1;
            end
        end else if (pop_valid) begin
            ptr <= ptr_dec;
            if (count != '0) begin
                count <= count - 1'b1;
            end
        end
    end

    assign ret_pc38  = stack[ptr];
    assign ras_index = ptr;
    assign ras_count = count;
    assign ras_empty = (count == '0);

endmodule

// File: tb/tb_ras.sv
// Directed testbench for ras: behavioural stack model checked every cycle plus literal expectations.
module tb_ras;

    logic        clk;
    logic        rst;
    logic        push_valid;
    logic [37:0] push_pc38;
    logic        pop_valid;
    logic        update_valid;
    logic [3:0]  update_ras_index;
    logic [4:0]  update_ras_count;
    logic [37:0] ret_pc38;
    logic [3:0]  ras_index;
    logic [4:0]  ras_count;
    logic        ras_empty;

    int checks = 0;
    int errors = 0;

    // Model: plain integer pointer/count and an array of return addresses.
    logic [37:0] m_arr [16];
    int          m_ptr;
    int          m_cnt;

    ras dut (
        .CLK              (clk),
        .RST              (rst),
        .push_valid       (push_valid),
        .push_pc38        (push_pc38),
        .pop_valid        (pop_valid),
        .update_valid     (update_valid),
        .update_ras_index (update_ras_index),
        .update_ras_count (update_ras_count),
        .ret_pc38         (ret_pc38),
        .ras_index        (ras_index),
        .ras_count        (ras_count),
        .ras_empty        (ras_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) m_arr[i] = 38'h0;
        m_ptr = 0;
        m_cnt = 0;
    endfunction

    function automatic void m_step(input logic push, input logic [37:0] pc, input logic pop,
                                   input logic upd, input int uidx, input int ucnt);
        if (upd) begin
            m_ptr = uidx;
            m_cnt = (ucnt > 16) ? 16 : ucnt;
        end else if (push && pop) begin
            m_arr[m_ptr] = pc;
            if (m_cnt == 0) m_cnt = 1;
        end else if (push) begin
            m_ptr = (m_ptr + 1) % 16;
            m_arr[m_ptr] = pc;
            m_cnt = (m_cnt + 1 > 16) ? 16 : m_cnt + 1;
        end else if (pop) begin
            m_ptr = (m_ptr + 15) % 16;
            m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
        end
    endfunction

    task automatic cyc(input logic push, input logic [37:0] pc, input logic pop,
                       input logic upd, input int uidx, input int ucnt);
        push_valid       = push;
        push_pc38        = pc;
        pop_valid        = pop;
        update_valid     = upd;
        update_ras_index = uidx[3:0];
        update_ras_count = ucnt[4:0];
        @(posedge clk);
        m_step(push, pc, pop, upd, uidx, ucnt);
        #1;
        push_valid   = 1'b0;
        pop_valid    = 1'b0;
        update_valid = 1'b0;
    endtask

    task automatic do_push(input logic [37:0] pc);
        cyc(1'b1, pc, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_pop();
        cyc(1'b0, 38'h0, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_state(input string name, input int idx, input int cnt, input logic [37:0] ret);
        chk({name, ".index"}, 64'(ras_index), 64'(idx));
        chk({name, ".count"}, 64'(ras_count), 64'(cnt));
        chk({name, ".ret"},   64'(ret_pc38),  64'(ret));
        chk({name, ".empty"}, 64'(ras_empty), 64'(cnt == 0));
    endtask

    // Every falling edge: outputs must match the model.
    always @(negedge clk) begin
        chk("cyc.ret",   64'(ret_pc38),  64'(m_arr[m_ptr]));
        chk("cyc.index", 64'(ras_index), 64'(m_ptr));
        chk("cyc.count", 64'(ras_count), 64'(m_cnt));
        chk("cyc.empty", 64'(ras_empty), 64'(m_cnt == 0));
    end

    initial begin
        push_valid       = 1'b0;
        push_pc38        = '0;
        pop_valid        = 1'b0;
        update_valid     = 1'b0;
        update_ras_index = '0;
        update_ras_count = '0;
        rst = 1'b1;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 0, 0, 38'h0);
        rst = 1'b0;

        // Basic push/pop
        do_push(38'h100);
        do_push(38'h200);
        do_push(38'h300);
        chk_state("push3", 3, 3, 38'h300);
        do_pop();
        chk_state("pop1", 2, 2, 38'h200);

        // Overflow wraps over the oldest entry, then drain
        do_reset();
        for (int i = 1; i <= 17; i++) do_push(38'(i));
        chk_state("full17", 1, 16, 38'h11);
        for (int i = 0; i < 16; i++) begin
            chk("drain.ret", 64'(ret_pc38), 64'(17 - i));
            do_pop();
        end
        chk("drain.empty", 64'(ras_empty), 64'd1);
        chk("drain.index", 64'(ras_index), 64'd1);

        // Underflow pop
        do_reset();
        do_pop();
        chk_state("underflow", 15, 0, 38'h0);

        // Simultaneous push+pop replaces top; from empty count goes to 1
        do_reset();
        cyc(1'b1, 38'h77, 1'b1, 1'b0, 0, 0);
        chk_state("pp_empty", 0, 1, 38'h77);
        do_reset();
        do_push(38'h10);
        do_push(38'h20);
        cyc(1'b1, 38'hABC, 1'b1, 1'b0, 0, 0);
        chk_state("pp_replace", 2, 2, 38'hABC);
        do_pop();
        chk_state("pp_below", 1, 1, 38'h10);

        // Checkpoint restore wins over a simultaneous push
        do_reset();
        for (int i = 1; i <= 4; i++) do_push(38'h1000 + 38'(i));
        chk_state("ckpt_rec", 4, 4, 38'h1004);
        for (int i = 5; i <= 7; i++) do_push(38'h1000 + 38'(i));
        cyc(1'b1, 38'hDEAD, 1'b0, 1'b1, 4, 4);
        chk_state("restore", 4, 4, 38'h1004);

        // Restored count above depth saturates
        cyc(1'b0, 38'h0, 1'b1, 1'b1, 7, 31);
        chk_state("clamp", 7, 16, 38'h1007);

        // Idle cycles hold state
        cyc(1'b0, 38'h0, 1'b0, 1'b0, 0, 0);
        cyc(1'b0, 38'h0, 1'b0, 1'b0, 0, 0);
        chk_state("hold", 7, 16, 38'h1007);

        // Asynchronous reset between edges
        do_reset();
        for (int i = 1; i <= 5; i++) do_push(38'h500 + 38'(i));
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        chk_state("async_rst", 0, 0, 38'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_push(38'h40);
        chk_state("after_rst", 1, 1, 38'h40);
        do_pop();
        chk_state("after_rst_pop", 0, 0, 38'h0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
